// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU writeback scheduler.
package fpu_sched_pkg;

  localparam int unsigned DEF_TAG_W       = 6;
  localparam int unsigned DEF_FMA_LAT     = 4;
  localparam int unsigned DEF_FAST_LAT    = 2;
  localparam int unsigned DEF_FROMINT_LAT = 2;
  localparam int unsigned DEF_TOINT_LAT   = 2;

  // Latencies are 1..8: LAT_W holds the latency, LAT_IDX_W a stage index.
  localparam int unsigned LAT_W     = 4;
  localparam int unsigned LAT_IDX_W = 3;

  typedef enum logic [2:0] {
    UNIT_FMA,
    UNIT_FAST,
    UNIT_FROMINT,
    UNIT_TOINT,
    UNIT_NONE
  } unit_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic                 wflags;
    logic [1:0]           type_tag;
  } wb_entry_t;

  // Integer writeback carries no type tag.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic                 wflags;
  } int_entry_t;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fpu_wb_delay_line.sv
// Fixed-depth shift line of writeback entries; head is the retiring stage.
module fpu_wb_delay_line
  import fpu_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [LAT_IDX_W-1:0] wr_idx,
  input  entry_t               wr_entry,
  output entry_t               head,
  output logic [DEPTH-1:0]     stage_valid
);

  entry_t st_q  [DEPTH];
  entry_t above [DEPTH];

  // Source for each stage on a plain shift; the top stage refills with invalid.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k < DEPTH - 1) begin : g_mid
      assign above[k] = st_q[k+1];
    end else begin : g_top
      assign above[k] = '0;
    end
    assign stage_valid[k] = st_q[k].valid;
  end

  // Shift every edge; a new entry lands at its latency slot, flush empties the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush)                                     st_q[k] <= '0;
        else if (wr_en && (wr_idx == LAT_IDX_W'(k)))   st_q[k] <= wr_entry;
        else                                           st_q[k] <= above[k];
      end
    end
  end

  assign head = st_q[0];

endmodule

// File: rtl/fpu_wb_scheduler.sv
// Accepts decoded FPU uops and schedules conflict-free writebacks on FP/int ports.
module fpu_wb_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned TAG_W       = DEF_TAG_W,
  parameter int unsigned FMA_LAT     = DEF_FMA_LAT,
  parameter int unsigned FAST_LAT    = DEF_FAST_LAT,
  parameter int unsigned FROMINT_LAT = DEF_FROMINT_LAT,
  parameter int unsigned TOINT_LAT   = DEF_TOINT_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [TAG_W-1:0] io_req_tag,
  input  logic             io_req_sigs_fma,
  input  logic             io_req_sigs_fastpipe,
  input  logic             io_req_sigs_fromint,
  input  logic             io_req_sigs_toint,
  input  logic             io_req_sigs_wflags,
  input  logic [1:0]       io_req_sigs_typeTagOut,
  input  logic             io_kill,
  output logic             io_fp_wb_valid,
  output logic [TAG_W-1:0] io_fp_wb_tag,
  output logic             io_fp_wb_wflags,
  output logic [1:0]       io_fp_wb_typeTag,
  output logic             io_int_wb_valid,
  output logic [TAG_W-1:0] io_int_wb_tag,
  output logic             io_int_wb_wflags,
  output logic             io_illegal,
  output logic             io_busy
);

  localparam int unsigned MAXL = max_lat(FMA_LAT, FAST_LAT, FROMINT_LAT);

  // Entry structs are sized by the package tag width.
  if (TAG_W != DEF_TAG_W) begin : g_tag_w_check
    $error("fpu_wb_scheduler: TAG_W must equal DEF_TAG_W");
  end

  unit_e            unit_c;
  logic [LAT_W-1:0] lat_c;
  logic             fp_target_c;
  logic             slot_busy_c;
  logic             accept_c;
  logic             illegal_q;

  wb_entry_t        fp_wr_entry;
  wb_entry_t        fp_head;
  logic [MAXL-1:0]  fp_valid;
  int_entry_t       int_wr_entry;
  int_entry_t       int_head;
  logic [TOINT_LAT-1:0] int_valid;

  // Unit decode, latency lookup and FP slot-collision check.
  always_comb begin
    unit_c      = UNIT_NONE;
    lat_c       = LAT_W'(1);
    fp_target_c = 1'b0;
    slot_busy_c = 1'b0;
    case ({io_req_sigs_fma, io_req_sigs_fastpipe, io_req_sigs_fromint, io_req_sigs_toint})
      4'b1000: unit_c = UNIT_FMA;
      4'b0100: unit_c = UNIT_FAST;
      4'b0010: unit_c = UNIT_FROMINT;
      4'b0001: unit_c = UNIT_TOINT;
      default: unit_c = UNIT_NONE;
    endcase
    case (unit_c)
      UNIT_FMA:     begin lat_c = LAT_W'(FMA_LAT);     fp_target_c = 1'b1; end
      UNIT_FAST:    begin lat_c = LAT_W'(FAST_LAT);    fp_target_c = 1'b1; end
      UNIT_FROMINT: begin lat_c = LAT_W'(FROMINT_LAT); fp_target_c = 1'b1; end
      UNIT_TOINT:   lat_c = LAT_W'(TOINT_LAT);
      default:      lat_c = LAT_W'(1);
    endcase
    // Writing st[L-1] this edge collides with whatever now sits in st[L].
    for (int k = 0; k < MAXL; k++) begin
      if ((lat_c == LAT_W'(k)) && fp_valid[k]) slot_busy_c = 1'b1;
    end
  end

  assign io_req_ready = !io_kill && !(io_req_valid && fp_target_c && slot_busy_c);
  assign accept_c     = io_req_valid && io_req_ready;

  // Entries written into the lines on acceptance.
  always_comb begin
    fp_wr_entry          = '0;
    fp_wr_entry.valid    = 1'b1;
    fp_wr_entry.tag      = io_req_tag;
    fp_wr_entry.wflags   = io_req_sigs_wflags;
    fp_wr_entry.type_tag = io_req_sigs_typeTagOut;
    int_wr_entry         = '0;
    int_wr_entry.valid   = 1'b1;
    int_wr_entry.tag     = io_req_tag;
    int_wr_entry.wflags  = io_req_sigs_wflags;
  end

  fpu_wb_delay_line #(
    .DEPTH   (MAXL),
    .entry_t (wb_entry_t)
  ) u_fp_line (
    .clock       (clock),
    .reset       (reset),
    .flush       (io_kill),
    .wr_en       (accept_c && fp_target_c),
    .wr_idx      (LAT_IDX_W'(lat_c - LAT_W'(1))),
    .wr_entry    (fp_wr_entry),
    .head        (fp_head),
    .stage_valid (fp_valid)
  );

  fpu_wb_delay_line #(
    .DEPTH   (TOINT_LAT),
    .entry_t (int_entry_t)
  ) u_int_line (
    .clock       (clock),
    .reset       (reset),
    .flush       (io_kill),
    .wr_en       (accept_c && (unit_c == UNIT_TOINT)),
    .wr_idx      (LAT_IDX_W'(TOINT_LAT - 1)),
    .wr_entry    (int_wr_entry),
    .head        (int_head),
    .stage_valid (int_valid)
  );

  // Malformed uops are swallowed and reported one cycle after acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= accept_c && (unit_c == UNIT_NONE);
  end

  assign io_fp_wb_valid   = fp_head.valid;
  assign io_fp_wb_tag     = fp_head.tag;
  assign io_fp_wb_wflags  = fp_head.wflags;
  assign io_fp_wb_typeTag = fp_head.type_tag;
  assign io_int_wb_valid  = int_head.valid;
  assign io_int_wb_tag    = int_head.tag;
  assign io_int_wb_wflags = int_head.wflags;
  assign io_illegal       = illegal_q;
  assign io_busy          = (|fp_valid) || (|int_valid);

endmodule
